uart_rx: RTL and testbench

- UART receiver, 8N1 (8 data bits, no parity, 1 stop bit), LSB first, fixed baud set by parameter.
- Sits between the board serial input pin and the core or debug logic in the FPGA top level.
- Complements the existing serial pin path by turning the incoming line into bytes.
- Output uses a single-entry holding register with a valid/ready handshake, plus framing-error and overrun pulses.

---
 rtl/uart_rx.sv | 130 +++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry valid/ready holding register.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t        state, state_nx;
    logic          rx_meta, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick, stop_tick, par_bad, byte_done, stop_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (!rx_s) state_nx = START;
            START: if (tick) state_nx = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (tick && bit_idx == 3'd7) state_nx = PARITY;
            PARITY: if (tick) state_nx = STOP;
`else
            DATA:  if (tick && bit_idx == 3'd7) state_nx = STOP;
`endif
            STOP:  if (tick) state_nx = rx_s ? IDLE : BREAK;
            BREAK: if (rx_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        tick      = (cnt == '0);
        stop_tick = (state == STOP) && tick;
        stop_bad  = stop_tick && !rx_s;
        byte_done = stop_tick && rx_s && !par_bad;
    end

    // Counter is reloaded every IDLE cycle so the start edge always sees HALF_BIT-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == IDLE) cnt <= HALF_M1;
            else if (tick)     cnt <= BIT_M1;
            else               cnt <= cnt - 1'b1;
            if (state == START) bit_idx <= '0;
            else if (state == DATA && tick) bit_idx <= bit_idx + 1'b1;
            if (state == DATA && tick) shreg <= {rx_s, shreg[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (rst)                          par_bit <= 1'b0;
        else if (state == PARITY && tick) par_bit <= rx_s;
    end

    assign par_bad = ^{shreg, par_bit};

    // A bad stop bit masks the parity result.
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= stop_tick && rx_s && par_bad;
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= byte_done && valid && !ready;
            if (byte_done && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit and accepted
// bytes are checked against a queue filled by the stimulus.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int HB  = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // From the cycle rx is driven low to the first cycle valid is seen high.
    localparam int LAT = 2 + HB + NB * CPB + 1;

    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1, ready = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .ready(ready),
        .frame_err(frame_err), .overrun(overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    logic [7:0] q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must be the next one the stimulus queued.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
            if (valid && ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", data);
                end else begin
                    automatic logic [7:0] e = q.pop_front();
                    if (data !== e) begin
                        errors++;
                        $display("FAIL byte: got %0h expected %0h", data, e);
                    end
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v, input int stop_n);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        hold(^b, CPB);
`endif
        hold(stop_v, stop_n);
        rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0, rise;
        logic v_after, bad;
        logic [7:0] b;

        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {frame_err, overrun}, 0);
        rst = 1'b0;

        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (valid || busy || frame_err || overrun) bad = 1'b1;
        end
        @(posedge clk); #1;
        check("idle_quiet", bad, 0);

        // 0x55 with ready high: exact latency and single-cycle valid.
        ready = 1'b1;
        q.push_back(8'h55);
        rise = -1;
        v_after = 1'bx;
        fork
            send(8'h55, 1'b1, CPB);
            begin
                k0 = cyc;
                for (int i = 0; i < 400 && rise < 0; i++) begin
                    @(negedge clk);
                    if (valid) rise = cyc;
                end
                @(negedge clk);
                v_after = valid;
            end
        join
        check("t55_latency", rise, k0 + LAT);
        check("t55_pulse", v_after, 0);
        hold(1'b1, 20);
        check("t55_noerr", {fe_cnt[3:0], ov_cnt[3:0]}, 0);

        // Back-to-back with ready low: second byte overruns.
        ready = 1'b0;
        q.push_back(8'hA3);
        send(8'hA3, 1'b1, CPB);
        send(8'h0F, 1'b1, CPB);
        hold(1'b1, 5);
        check("ovr_valid", valid, 1);
        check("ovr_data", data, 8'hA3);
        check("ovr_pulse", ov_cnt, 1);
        ready = 1'b1;
        @(posedge clk); #1;
        check("ovr_drain", valid, 0);
        hold(1'b1, 10);

        // Drain and load on the same edge.
        ready = 1'b0;
        q.push_back(8'h3C);
        q.push_back(8'hC3);
        send(8'h3C, 1'b1, CPB);
        hold(1'b1, 5);
        check("sim_pend", data, 8'h3C);
        fork
            send(8'hC3, 1'b1, CPB);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1; ready = 1'b1;
                @(posedge clk);
                #1; ready = 1'b0;
            end
        join
        check("sim_valid", valid, 1);
        check("sim_data", data, 8'hC3);
        check("sim_noovr", ov_cnt, 1);
        ready = 1'b1;
        @(posedge clk); #1;
        check("sim_drain", valid, 0);
        hold(1'b1, 10);

        // Stop bit held low: frame error then BREAK until the line recovers.
        send(8'h7E, 1'b0, 40);
        check("brk_busy", busy, 1);
        hold(1'b1, 5);
        check("brk_idle", busy, 0);
        check("brk_valid", valid, 0);
        check("brk_fe", fe_cnt, 1);
        q.push_back(8'h81);
        send(8'h81, 1'b1, CPB);
        hold(1'b1, 10);
        check("brk_next", q.size(), 0);

        // Short low glitch is rejected at the start-bit check.
        hold(1'b0, 4);
        check("glitch_busy", busy, 1);
        hold(1'b1, 20);
        check("glitch_idle", {busy, valid}, 0);
        check("glitch_noerr", {fe_cnt[3:0], ov_cnt[3:0]}, 8'h11);

        // Reset mid-DATA clears a pending byte and the partial frame.
        ready = 1'b0;
        send(8'h5A, 1'b1, CPB);
        hold(1'b1, 3);
        check("rstm_pend", valid, 1);
        hold(1'b0, CPB);
        hold(1'b1, CPB);
        hold(1'b0, CPB);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk); #1;
        check("rstm_clear", {valid, busy}, 0);
        rst = 1'b0;
        ready = 1'b1;
        hold(1'b1, 10);
        q.push_back(8'h42);
        send(8'h42, 1'b1, CPB);
        hold(1'b1, 10);
        check("rstm_next", q.size(), 0);

        // Random bytes with random idle gaps, consumer always ready.
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            q.push_back(b);
            send(b, 1'b1, CPB);
            hold(1'b1, $urandom_range(0, 12));
        end
        hold(1'b1, 20);
        check("rand_drain", q.size(), 0);
        check("final_fe", fe_cnt, 1);
        check("final_ovr", ov_cnt, 1);
        check("final_pe", pe_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
